cell_evolution: RTL and testbench
=================================

Name: cell_evolution

Overview:
Per-cell Game-of-Life rule engine. Takes the 3x3 neighbourhood of one cell and produces the cell's next-generation state. It drives this result combinationally, for the round scanner that writes it in the same cycle, and also as a registered result with a valid flag. It additionally keeps birth/death statistics per generation. It sits between the round scanner (neighbourhood gatherer) and the frame RAM write port.

Parameters:
BIRTH_MASK, 9'b000001000, bit k set means a dead cell with k live neighbours becomes alive (default: birth on 3).
SURVIVE_MASK, 9'b000001100, bit k set means a live cell with k live neighbours stays alive (default: survive on 2 or 3).
CNT_WIDTH, 24, width of the birth/death statistic counters.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
status  input  9  neighbourhood; [0]=centre (i,j), then clockwise: [1]=(i,j+1), [2]=(i+1,j+1), [3]=(i+1,j), [4]=(i+1,j-1), [5]=(i,j-1), [6]=(i-1,j-1), [7]=(i-1,j), [8]=(i-1,j+1).
in_valid  input  1  status holds a cell to be evaluated this cycle.
gen_clear  input  1  synchronous clear of the statistic counters.
live  output  1  combinational next state of the centre cell.
neighbor_count  output  4  combinational count of set bits in status[8:1], range 0..8.
live_q  output  1  registered live, captured when in_valid=1.
out_valid  output  1  registered in_valid (one-cycle pulse per accepted cell).
birth_cnt  output  CNT_WIDTH  number of accepted cells with status[0]=0 and live=1.
death_cnt  output  CNT_WIDTH  number of accepted cells with status[0]=1 and live=0.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- neighbor_count = popcount(status[8:1]); the centre bit is never counted. Zero-width/out-of-grid neighbours are supplied as 0 by the caller.
- live = status[0] ? SURVIVE_MASK[neighbor_count] : BIRTH_MASK[neighbor_count]. Purely combinational, zero latency, and independent of in_valid and reset.
- Registered path, 1-cycle latency:
  - on the clk edge with in_valid=1: live_q <= live, out_valid <= 1.
  - with in_valid=0: out_valid <= 0 and live_q holds its value.
- Statistics, updated on the clk edge when in_valid=1:
  - birth_cnt increments if status[0]=0 and live=1.
  - death_cnt increments if status[0]=1 and live=0.
  - Counters saturate at all-ones; they never wrap.
- gen_clear=1 zeroes both counters on that edge and has priority over a simultaneous increment; live_q and out_valid still update normally that cycle.
- Reset (rst_n=0, any time, including mid-stream): live_q=0, out_valid=0, birth_cnt=0, death_cnt=0 immediately. The combinational live and neighbor_count remain functional during reset.
- No internal state machine beyond these registers; back-to-back in_valid every cycle is supported at full rate.

Test Plan:
- Exhaustive sweep of all 512 status values, default masks: live=1 exactly when (status[0]=1 and count in {2,3}) or (status[0]=0 and count=3). Example: status=9'b000001110 gives live=1, count=3; status=9'b111111111 gives live=0, count=8.
- Centre excluded from count: status=9'b000000111 -> neighbor_count=2, live=1. Then status=9'b000000110 -> count=2, live=0.
- Latency: pulse in_valid=1 with status=9'b000001110 for one cycle, then idle -> next cycle live_q=1, out_valid=1; the following cycle out_valid=0 and live_q stays 1.
- Statistics: feed 3 births (9'b000001110), 2 deaths (9'b000000001), 1 survival (9'b000000111) -> birth_cnt=3, death_cnt=2. gen_clear together with a birth -> both counters 0.
- Saturation, with CNT_WIDTH=2: 5 births -> birth_cnt=3.
- Async reset mid-stream: drop rst_n between clock edges while out_valid=1 and counters are nonzero -> all registered outputs become 0 immediately, without waiting for a clock edge. live still tracks status.

Source files
------------

// File: rtl/cell_evolution_if.sv
// Neighbourhood-in / next-state-out bundle between the round scanner and the
// Game-of-Life rule engine. The master side is the scanner (drives status,
// in_valid, gen_clear); the slave side is the rule engine.
interface cell_evolution_if #(
    parameter int unsigned CNT_WIDTH = 24
) ();
    // scanner -> engine
    logic [8:0]           status;
    logic                 in_valid;
    logic                 gen_clear;

    // engine -> scanner / frame RAM write port
    logic                 live;
    logic [3:0]           neighbor_count;
    logic                 live_q;
    logic                 out_valid;
    logic [CNT_WIDTH-1:0] birth_cnt;
    logic [CNT_WIDTH-1:0] death_cnt;

    modport master (
        output status,
        output in_valid,
        output gen_clear,
        input  live,
        input  neighbor_count,
        input  live_q,
        input  out_valid,
        input  birth_cnt,
        input  death_cnt
    );

    modport slave (
        input  status,
        input  in_valid,
        input  gen_clear,
        output live,
        output neighbor_count,
        output live_q,
        output out_valid,
        output birth_cnt,
        output death_cnt
    );
endinterface

// File: rtl/cell_evolution.sv
// Per-cell Game-of-Life rule engine.
// Takes the 3x3 neighbourhood of one cell (centre in status[0], ring in
// status[8:1]) and produces the next-generation state combinationally and as a
// registered result with a valid pulse. Also keeps saturating per-generation
// birth/death counters that the scanner clears with gen_clear.
module cell_evolution #(
    parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
    parameter int unsigned CNT_WIDTH    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    cell_evolution_if.slave  bus
);

    logic [3:0]           count;
    logic                 live_next;
    logic                 birth_evt;
    logic                 death_evt;

    logic                 live_hold_d,  live_hold_q;
    logic                 out_valid_d,  out_valid_q;
    logic [CNT_WIDTH-1:0] birth_cnt_d,  birth_cnt_q;
    logic [CNT_WIDTH-1:0] death_cnt_d,  death_cnt_q;

    // Population count of the eight ring neighbours; the centre is never counted.
    always_comb begin
        count = '0;
        for (int unsigned i = 1; i < 9; i++) begin
            count = count + {3'b000, bus.status[i]};
        end
    end

    // Rule lookup: live centres consult the survive mask, dead centres the birth mask.
    always_comb begin
        live_next = bus.status[0] ? SURVIVE_MASK[count] : BIRTH_MASK[count];
        birth_evt = !bus.status[0] &&  live_next;
        death_evt =  bus.status[0] && !live_next;
    end

    // Next-state for the registered result and the saturating statistics.
    always_comb begin
        live_hold_d = live_hold_q;
        out_valid_d = bus.in_valid;
        birth_cnt_d = birth_cnt_q;
        death_cnt_d = death_cnt_q;

        if (bus.in_valid) begin
            live_hold_d = live_next;
            if (birth_evt && (birth_cnt_q != '1)) begin
                birth_cnt_d = birth_cnt_q + CNT_WIDTH'(1);
            end
            if (death_evt && (death_cnt_q != '1)) begin
                death_cnt_d = death_cnt_q + CNT_WIDTH'(1);
            end
        end

        // Clearing wins over an increment landing on the same edge.
        if (bus.gen_clear) begin
            birth_cnt_d = '0;
            death_cnt_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_hold_q <= 1'b0;
            out_valid_q <= 1'b0;
            birth_cnt_q <= '0;
            death_cnt_q <= '0;
        end else begin
            live_hold_q <= live_hold_d;
            out_valid_q <= out_valid_d;
            birth_cnt_q <= birth_cnt_d;
            death_cnt_q <= death_cnt_d;
        end
    end

    assign bus.live           = live_next;
    assign bus.neighbor_count = count;
    assign bus.live_q         = live_hold_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.birth_cnt      = birth_cnt_q;
    assign bus.death_cnt      = death_cnt_q;

endmodule

// File: tb/tb_cell_evolution.sv
// Directed bench for cell_evolution: a 24-bit-counter instance and a 2-bit
// instance (for saturation) driven with identical stimulus. Registered results
// are predicted into a queue when a cell is driven and popped after the edge.
module tb_cell_evolution;

    logic clk;
    logic rst_n;

    cell_evolution_if #(.CNT_WIDTH(24)) bus1 ();
    cell_evolution_if #(.CNT_WIDTH(2))  bus2 ();

    cell_evolution #(
        .BIRTH_MASK   (9'b000001000),
        .SURVIVE_MASK (9'b000001100),
        .CNT_WIDTH    (24)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    cell_evolution #(
        .BIRTH_MASK   (9'b000001000),
        .SURVIVE_MASK (9'b000001100),
        .CNT_WIDTH    (2)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // scoreboard / model state
    logic        sb_q[$];
    logic        exp_lq;
    int unsigned exp_b1, exp_d1, exp_b2, exp_d2;
    localparam int unsigned SAT1 = 32'h00FF_FFFF;
    localparam int unsigned SAT2 = 3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int unsigned ref_count(input logic [8:0] s);
        int unsigned c = 0;
        for (int k = 1; k < 9; k++) if (s[k]) c++;
        return c;
    endfunction

    // Conway B3/S23 written as a plain rule, not a mask lookup.
    function automatic logic ref_live(input logic [8:0] s);
        int unsigned c = ref_count(s);
        if (s[0]) return (c == 2) || (c == 3);
        return c == 3;
    endfunction

    task automatic reset_model();
        sb_q.delete();
        exp_lq = 1'b0;
        exp_b1 = 0; exp_d1 = 0; exp_b2 = 0; exp_d2 = 0;
    endtask

    task automatic check_regs(input string tag, input logic ov);
        check({tag, ".out_valid"}, {31'd0, bus1.out_valid}, {31'd0, ov});
        check({tag, ".live_q"},    {31'd0, bus1.live_q},    {31'd0, exp_lq});
        check({tag, ".birth1"},    {8'd0, bus1.birth_cnt},  exp_b1);
        check({tag, ".death1"},    {8'd0, bus1.death_cnt},  exp_d1);
        check({tag, ".birth2"},    {30'd0, bus2.birth_cnt}, exp_b2);
        check({tag, ".death2"},    {30'd0, bus2.death_cnt}, exp_d2);
    endtask

    // Called 1 time unit after a rising edge: drive, check combinational
    // outputs, cross the next edge, then check registered outputs.
    task automatic cycle(input string tag, input logic [8:0] s, input logic v, input logic clr);
        logic m;
        bus1.status = s; bus1.in_valid = v; bus1.gen_clear = clr;
        bus2.status = s; bus2.in_valid = v; bus2.gen_clear = clr;
        m = ref_live(s);
        #1;
        check({tag, ".count"}, {28'd0, bus1.neighbor_count}, ref_count(s));
        check({tag, ".live"},  {31'd0, bus1.live},           {31'd0, m});
        if (v) sb_q.push_back(m);
        @(posedge clk);
        if (clr) begin
            exp_b1 = 0; exp_d1 = 0; exp_b2 = 0; exp_d2 = 0;
        end else if (v) begin
            if (!s[0] && m) begin
                if (exp_b1 != SAT1) exp_b1++;
                if (exp_b2 != SAT2) exp_b2++;
            end
            if (s[0] && !m) begin
                if (exp_d1 != SAT1) exp_d1++;
                if (exp_d2 != SAT2) exp_d2++;
            end
        end
        #1;
        if (v && sb_q.size() > 0) exp_lq = sb_q.pop_front();
        check_regs(tag, v);
    endtask

    initial begin
        rst_n = 1'b0;
        bus1.status = '0; bus1.in_valid = 1'b0; bus1.gen_clear = 1'b0;
        bus2.status = '0; bus2.in_valid = 1'b0; bus2.gen_clear = 1'b0;
        reset_model();
        #2;
        check_regs("reset", 1'b0);

        @(posedge clk); #1;
        rst_n = 1'b1;

        // spot values from the rule table
        cycle("ex_0e",  9'b000001110, 1'b0, 1'b0);
        cycle("ex_1ff", 9'b111111111, 1'b0, 1'b0);

        // exhaustive sweep, back-to-back accepted cells
        for (int unsigned s = 0; s < 512; s++) begin
            cycle("sweep", 9'(s), 1'b1, 1'b0);
        end

        // centre bit excluded from the count
        cycle("ctr_on",  9'b000000111, 1'b0, 1'b0);
        cycle("ctr_off", 9'b000000110, 1'b0, 1'b0);

        // one-cycle latency, then hold
        cycle("lat_in",   9'b000001110, 1'b1, 1'b0);
        check("lat.live_q_abs", {31'd0, bus1.live_q}, 32'd1);
        cycle("lat_idle", 9'b000000000, 1'b0, 1'b0);
        check("lat.hold_abs",   {31'd0, bus1.live_q}, 32'd1);

        // statistics: 3 births, 2 deaths, 1 survival
        cycle("clr", 9'b000000000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle("stat_b", 9'b000001110, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle("stat_d", 9'b000000001, 1'b1, 1'b0);
        cycle("stat_s", 9'b000000111, 1'b1, 1'b0);
        check("stat.birth_abs", {8'd0, bus1.birth_cnt}, 32'd3);
        check("stat.death_abs", {8'd0, bus1.death_cnt}, 32'd2);

        // clear beats a simultaneous birth; registered path still updates
        cycle("clr_b", 9'b000001110, 1'b1, 1'b1);
        check("clr_b.birth_abs", {8'd0, bus1.birth_cnt}, 32'd0);
        check("clr_b.death_abs", {8'd0, bus1.death_cnt}, 32'd0);

        // saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) cycle("sat", 9'b000001110, 1'b1, 1'b0);
        check("sat.birth2_abs", {30'd0, bus2.birth_cnt}, 32'd3);
        check("sat.birth1_abs", {8'd0, bus1.birth_cnt},  32'd5);

        // async reset between edges while out_valid=1 and counters nonzero
        cycle("pre_rst", 9'b000000001, 1'b1, 1'b0);
        bus1.in_valid = 1'b0; bus2.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        check_regs("async_rst", 1'b0);
        bus1.status = 9'b000001110; bus2.status = 9'b000001110;
        #1;
        check("rst.live_tracks", {31'd0, bus1.live}, 32'd1);
        check("rst.count",       {28'd0, bus1.neighbor_count}, 32'd3);
        @(posedge clk); #1;
        check_regs("rst_held", 1'b0);
        rst_n = 1'b1;

        // operation resumes after reset
        cycle("post_b", 9'b000001110, 1'b1, 1'b0);
        cycle("post_d", 9'b111111111, 1'b1, 1'b0);
        cycle("post_i", 9'b000000000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
